// File: rtl/excp_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// excp_irq_ctrl_pkg
//   Shared definitions for the machine-mode interrupt controller slice.
//   The `define block carries the values that the trap unit and the mcause
//   CSR logic also depend on (XLEN, cause codes, mip/mie bit positions,
//   FSM state encodings). They are guarded so that any other file of the
//   slice can pull them in without redefinition.
//   The package wraps the same values as typed localparams, the FSM state
//   enum and a helper that forms an interrupt mcause word.
// ---------------------------------------------------------------------------
`ifndef MCU_DEFINES_SVH
`define MCU_DEFINES_SVH
`define XLEN          32
`define MEI_CODE      11
`define MSI_CODE      3
`define MTI_CODE      7
`define MIP_MSIP_BIT  3
`define MIP_MTIP_BIT  7
`define MIP_MEIP_BIT  11
`define IRQ_ST_IDLE   2'd0
`define IRQ_ST_REQ    2'd1
`define IRQ_ST_HDLR   2'd2
`endif

package excp_irq_ctrl_pkg;

  localparam int XLEN     = `XLEN;
  localparam int MSIP_BIT = `MIP_MSIP_BIT;
  localparam int MTIP_BIT = `MIP_MTIP_BIT;
  localparam int MEIP_BIT = `MIP_MEIP_BIT;

  localparam logic [3:0] MEI_CODE_DEF = 4'(`MEI_CODE);
  localparam logic [3:0] MSI_CODE_DEF = 4'(`MSI_CODE);
  localparam logic [3:0] MTI_CODE_DEF = 4'(`MTI_CODE);

  typedef enum logic [1:0] {
    IRQ_IDLE    = `IRQ_ST_IDLE,
    IRQ_REQ     = `IRQ_ST_REQ,
    IRQ_HANDLER = `IRQ_ST_HDLR
  } irq_state_e;

  // Interrupt mcause: top bit flags "interrupt", code lives in the low nibble.
  function automatic logic [XLEN-1:0] make_irq_cause(input logic [3:0] code);
    logic [XLEN-1:0] c;
    c           = '0;
    c[XLEN-1]   = 1'b1;
    c[3:0]      = code;
    return c;
  endfunction

endpackage

// File: rtl/excp_irq_sync.sv
// ---------------------------------------------------------------------------
// excp_irq_sync
//   Two-flop synchronizer bank with synchronous active-high reset. Used to
//   bring asynchronous interrupt levels into the clk domain.
//   Ports:
//     clk  - destination clock
//     rst  - synchronous, active-high reset; clears both stages to 0
//     d    - asynchronous input levels
//     q    - synchronized levels (two clk cycles behind d)
// ---------------------------------------------------------------------------
module excp_irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/excp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// excp_irq_ctrl
//   Machine-mode interrupt controller. Qualifies the external, software and
//   timer interrupt levels with mie / mstatus.MIE, picks the winner by fixed
//   priority (MEI > MSI > MTI), and raises one registered, held-stable request
//   towards the trap unit. After the trap unit acknowledges, further requests
//   are masked until the handler's mret commits. Also drives the live mip view.
//
//   Optional build macro: IRQ_SYNC_EN
//     defined   - ext_irq and sw_irq pass through a 2-flop synchronizer
//                 (excp_irq_sync) before pend logic and csr_mip.
//     undefined - both levels are used directly.
//   tmr_irq already arrives in the clk domain and is never resynchronized.
//
//   Ports:
//     clk, rst         - clock, synchronous active-high reset
//     tmr_irq          - timer interrupt level (from excp_tmr_irq)
//     sw_irq, ext_irq  - software / external interrupt levels
//     csr_mie          - mie CSR (bits 3, 7, 11 used)
//     csr_mstatus_mie  - mstatus.MIE global enable
//     mret_commit      - one-cycle pulse when mret retires
//     irq_req          - request to the trap unit (registered)
//     irq_cause        - mcause value for the request (registered, held)
//     irq_ack          - trap unit accepted the request this cycle
//     csr_mip          - live mip view (bits 3, 7, 11)
//     irq_busy         - high while a request or its handler is outstanding
// ---------------------------------------------------------------------------
module excp_irq_ctrl
  import excp_irq_ctrl_pkg::*;
#(
  parameter logic [3:0] MEI_CODE = MEI_CODE_DEF,
  parameter logic [3:0] MSI_CODE = MSI_CODE_DEF,
  parameter logic [3:0] MTI_CODE = MTI_CODE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tmr_irq,
  input  logic            sw_irq,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] csr_mie,
  input  logic            csr_mstatus_mie,
  input  logic            mret_commit,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  input  logic            irq_ack,
  output logic [XLEN-1:0] csr_mip,
  output logic            irq_busy
);

  irq_state_e state;

  logic       ext_lvl;
  logic       sw_lvl;
  logic       pend_e;
  logic       pend_s;
  logic       pend_t;
  logic       pend_any;
  logic [3:0] pend_code;

  // Only three mie bits matter; the rest are folded here so they are
  // visibly consumed.
  logic unused_mie_bits;
  assign unused_mie_bits = ^{csr_mie[XLEN-1:MEIP_BIT+1],
                             csr_mie[MEIP_BIT-1:MTIP_BIT+1],
                             csr_mie[MTIP_BIT-1:MSIP_BIT+1],
                             csr_mie[MSIP_BIT-1:0]};

`ifdef IRQ_SYNC_EN
  logic [1:0] sync_q;

  excp_irq_sync #(
    .WIDTH (2)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ext_irq, sw_irq}),
    .q   (sync_q)
  );

  assign ext_lvl = sync_q[1];
  assign sw_lvl  = sync_q[0];
`else
  assign ext_lvl = ext_irq;
  assign sw_lvl  = sw_irq;
`endif

  assign pend_e = ext_lvl & csr_mie[MEIP_BIT] & csr_mstatus_mie;
  assign pend_s = sw_lvl  & csr_mie[MSIP_BIT] & csr_mstatus_mie;
  assign pend_t = tmr_irq & csr_mie[MTIP_BIT] & csr_mstatus_mie;

  // Fixed-priority pick of the cause code; only consulted in IDLE.
  always_comb begin
    pend_any  = pend_e | pend_s | pend_t;
    pend_code = MTI_CODE;
    if (pend_e) begin
      pend_code = MEI_CODE;
    end else if (pend_s) begin
      pend_code = MSI_CODE;
    end
  end

  // mip is a live view of the (possibly synchronized) levels.
  always_comb begin
    csr_mip           = '0;
    csr_mip[MSIP_BIT] = sw_lvl;
    csr_mip[MTIP_BIT] = tmr_irq;
    csr_mip[MEIP_BIT] = ext_lvl;
  end

  // Request FSM. Outputs are registered alongside the state so irq_req and
  // irq_cause never glitch. Once a request is out, inputs are ignored until
  // the ack; once acked, nothing new is issued until mret. An ack arriving
  // together with mret in HANDLER is simply irrelevant there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IRQ_IDLE;
      irq_req   <= 1'b0;
      irq_cause <= '0;
      irq_busy  <= 1'b0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (pend_any) begin
            state     <= IRQ_REQ;
            irq_req   <= 1'b1;
            irq_busy  <= 1'b1;
            irq_cause <= make_irq_cause(pend_code);
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            state   <= IRQ_HANDLER;
            irq_req <= 1'b0;
          end
        end
        IRQ_HANDLER: begin
          if (mret_commit) begin
            state    <= IRQ_IDLE;
            irq_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IRQ_IDLE;
          irq_req  <= 1'b0;
          irq_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_excp_irq_ctrl
//   Directed bench for excp_irq_ctrl. A behavioural model tracks the request
//   handshake (request outstanding / handler running) and picks causes by
//   walking a priority list, with mip bit position == cause code. Every
//   cycle all four outputs are compared against it; pinned literals at
//   key points of the sequence anchor the model itself.
//   Honors IRQ_SYNC_EN (model delays ext/sw by two cycles).
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module tb_excp_irq_ctrl;

  localparam int W = `XLEN;

  logic         clk;
  logic         rst;
  logic         tmr_irq;
  logic         sw_irq;
  logic         ext_irq;
  logic [W-1:0] csr_mie;
  logic         csr_mstatus_mie;
  logic         mret_commit;
  logic         irq_req;
  logic [W-1:0] irq_cause;
  logic         irq_ack;
  logic [W-1:0] csr_mip;
  logic         irq_busy;

  int vec_count  = 0;
  int miss_count = 0;

  // model state
  bit           m_wait_ack;
  bit           m_in_handler;
  logic [W-1:0] m_cause;
  bit           m_ext_h1, m_ext_h2, m_sw_h1, m_sw_h2;

  int prio_list[3] = '{11, 3, 7};

  excp_irq_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .tmr_irq         (tmr_irq),
    .sw_irq          (sw_irq),
    .ext_irq         (ext_irq),
    .csr_mie         (csr_mie),
    .csr_mstatus_mie (csr_mstatus_mie),
    .mret_commit     (mret_commit),
    .irq_req         (irq_req),
    .irq_cause       (irq_cause),
    .irq_ack         (irq_ack),
    .csr_mip         (csr_mip),
    .irq_busy        (irq_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Levels as the controller sees them (after optional synchronizer).
  function automatic bit ext_seen();
`ifdef IRQ_SYNC_EN
    return m_ext_h2;
`else
    return ext_irq;
`endif
  endfunction

  function automatic bit sw_seen();
`ifdef IRQ_SYNC_EN
    return m_sw_h2;
`else
    return sw_irq;
`endif
  endfunction

  function automatic logic [W-1:0] expected_mip();
    logic [W-1:0] m;
    m     = '0;
    m[3]  = sw_seen();
    m[7]  = tmr_irq;
    m[11] = ext_seen();
    return m;
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic modelUpdate();
    logic [W-1:0] lv;
    int           winner;
    if (rst) begin
      m_wait_ack   = 0;
      m_in_handler = 0;
      m_cause      = '0;
      m_ext_h1 = 0; m_ext_h2 = 0; m_sw_h1 = 0; m_sw_h2 = 0;
      return;
    end
    lv     = expected_mip();
    winner = -1;
    foreach (prio_list[k]) begin
      if (winner < 0 && lv[prio_list[k]] && csr_mie[prio_list[k]] && csr_mstatus_mie)
        winner = prio_list[k];
    end
    if (m_in_handler) begin
      if (mret_commit) m_in_handler = 0;
    end else if (m_wait_ack) begin
      if (irq_ack) begin
        m_wait_ack   = 0;
        m_in_handler = 1;
      end
    end else if (winner >= 0) begin
      m_wait_ack = 1;
      m_cause    = (W'(1) << (W - 1)) | W'(winner);
    end
    m_ext_h2 = m_ext_h1; m_ext_h1 = ext_irq;
    m_sw_h2  = m_sw_h1;  m_sw_h1  = sw_irq;
  endtask

  task automatic compareOne(input string name, input logic [W-1:0] got,
                            input logic [W-1:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic checkOutput();
    compareOne("irq_req",   W'(irq_req),  W'(m_wait_ack));
    compareOne("irq_busy",  W'(irq_busy), W'(m_wait_ack | m_in_handler));
    compareOne("irq_cause", irq_cause,    m_cause);
    compareOne("csr_mip",   csr_mip,      expected_mip());
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic applyStimulus(input bit r, input bit t, input bit s, input bit e,
                               input logic [W-1:0] mie, input bit mst,
                               input bit mret, input bit ack);
    rst             = r;
    tmr_irq         = t;
    sw_irq          = s;
    ext_irq         = e;
    csr_mie         = mie;
    csr_mstatus_mie = mst;
    mret_commit     = mret;
    irq_ack         = ack;
  endtask

  task automatic pin(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    compareOne(name, got, exp);
  endtask

  localparam logic [W-1:0] C_MEI = (W'(1) << (W - 1)) | W'(11);
  localparam logic [W-1:0] C_MSI = (W'(1) << (W - 1)) | W'(3);
  localparam logic [W-1:0] C_MTI = (W'(1) << (W - 1)) | W'(7);

  initial begin
    m_wait_ack = 0; m_in_handler = 0; m_cause = '0;
    m_ext_h1 = 0; m_ext_h2 = 0; m_sw_h1 = 0; m_sw_h2 = 0;

    // reset with everything pending and enabled
    applyStimulus(1, 1, 1, 1, W'(12'h888), 1, 0, 0);
    tick(3);
    pin("rst_req",   W'(irq_req),  '0);
    pin("rst_cause", irq_cause,    '0);
    pin("rst_busy",  W'(irq_busy), '0);

`ifndef IRQ_SYNC_EN
    // release: IDLE latches MEI, request visible one cycle later
    applyStimulus(0, 1, 1, 1, W'(12'h888), 1, 0, 0);
    tick();
    pin("first_req",   W'(irq_req), W'(1));
    pin("first_cause", irq_cause,   C_MEI);

    // ack -> HANDLER; sources and acks toggling must not re-request
    applyStimulus(0, 1, 1, 1, W'(12'h888), 1, 0, 1);
    tick();
    pin("ack_req",  W'(irq_req),  '0);
    pin("ack_busy", W'(irq_busy), W'(1));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i[0], i[1], ~i[0], W'(12'h888), 1, 0, i[0]);
      tick();
    end
    pin("hdlr_req", W'(irq_req), '0);

    // mret with no sources -> idle; stray ack in idle ignored
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 1, 0);
    tick();
    pin("mret_busy", W'(irq_busy), '0);
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 1);
    tick();
    pin("idle_ack_req", W'(irq_req), '0);

    // timer request held through withdrawal, mret, higher arrival, disable
    applyStimulus(0, 1, 0, 0, W'(12'h888), 1, 0, 0);
    tick();
    pin("tmr_cause", irq_cause, C_MTI);
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 0);
    tick(5);
    pin("tmr_hold_req",   W'(irq_req), W'(1));
    pin("tmr_hold_cause", irq_cause,   C_MTI);
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 1, W'(12'h888), 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, W'(12'h888), 0, 0, 0);
    tick();
    pin("req_ignore_cause", irq_cause, C_MTI);
    pin("req_ignore_req",   W'(irq_req), W'(1));

    // ack with new source pending; then mret+ack together acts as mret
    applyStimulus(0, 0, 0, 1, W'(12'h888), 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 1, W'(12'h888), 1, 1, 1);
    tick();
    pin("mret_ack_busy", W'(irq_busy), '0);
    applyStimulus(0, 0, 0, 1, W'(12'h888), 1, 0, 0);
    tick();
    pin("rereq_cause", irq_cause, C_MEI);

    // MSI beats MTI; mret with tmr still high re-requests 2 cycles later
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 0);
    tick();
    applyStimulus(0, 1, 1, 0, W'(12'h888), 1, 0, 0);
    tick();
    pin("msi_cause", irq_cause, C_MSI);
    applyStimulus(0, 1, 1, 0, W'(12'h888), 1, 0, 1);
    tick();
    applyStimulus(0, 1, 0, 0, W'(12'h888), 1, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 0, W'(12'h888), 1, 1, 0);
    tick();
    pin("post_mret1_req", W'(irq_req), '0);
    applyStimulus(0, 1, 0, 0, W'(12'h888), 1, 0, 0);
    tick();
    pin("post_mret2_req", W'(irq_req), W'(1));
    pin("post_mret2_cause", irq_cause, C_MTI);

    // ext masked by mie[11] still shows in mip; enabling it requests
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 1, W'(12'h088), 1, 0, 0);
    tick(2);
    pin("masked_req", W'(irq_req), '0);
    pin("masked_mip", csr_mip, W'(12'h800));
    applyStimulus(0, 0, 0, 1, W'(12'h888), 1, 0, 0);
    tick();
    pin("unmask_cause", irq_cause, C_MEI);

    // reset mid-request
    applyStimulus(1, 0, 0, 1, W'(12'h888), 1, 0, 0);
    tick();
    pin("midrst_req",   W'(irq_req), '0);
    pin("midrst_cause", irq_cause,   '0);
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 0);
    tick(2);

    // global disable blocks everything
    applyStimulus(0, 1, 1, 1, W'(12'h888), 0, 0, 0);
    tick(2);
    pin("gdis_req", W'(irq_req), '0);
    pin("gdis_mip", csr_mip, W'(12'h888));
    applyStimulus(0, 1, 1, 1, W'(12'h888), 1, 0, 0);
    tick();
    pin("genable_cause", irq_cause, C_MEI);
`else
    // synchronizer latency: mip at N+2, request at N+3
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 0);
    tick(2);
    applyStimulus(0, 0, 0, 1, W'(12'h888), 1, 0, 0);
    tick();
    pin("sync_mip_n1", csr_mip, '0);
    tick();
    pin("sync_mip_n2", csr_mip, W'(12'h800));
    pin("sync_req_n2", W'(irq_req), '0);
    tick();
    pin("sync_req_n3", W'(irq_req), W'(1));
    pin("sync_cause",  irq_cause,   C_MEI);
    applyStimulus(0, 1, 1, 0, W'(12'h888), 1, 0, 1);
    tick(2);
    applyStimulus(0, 1, 1, 0, W'(12'h888), 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, W'(12'h888), 1, 0, 0);
    tick(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/excp_irq_ctrl.md
Name: excp_irq_ctrl

Overview:
- Sits directly downstream of excp_tmr_irq. Consumes its timer-interrupt level, plus the software and external interrupt levels.
- Qualifies the three levels with the mie / mstatus.MIE state and arbitrates them by fixed RISC-V priority.
- Issues one registered, held-stable interrupt request (cause + handshake) to the trap/exception unit, then masks further requests until the handler's mret commits.
- Also supplies the live mip view for CSR reads.

Parameters:
- MEI_CODE, 11, cause code for the machine external interrupt
- MSI_CODE, 3, cause code for the machine software interrupt
- MTI_CODE, 7, cause code for the machine timer interrupt

Ports:
- clk  in  1  CPU internal clock
- rst  in  1  synchronous, active-high reset
- tmr_irq  in  1  timer interrupt level from excp_tmr_irq, already in the clk domain
- sw_irq  in  1  software interrupt level (msip)
- ext_irq  in  1  external interrupt level
- csr_mie  in  `XLEN  mie CSR value; bits 3, 7, 11 used
- csr_mstatus_mie  in  1  mstatus.MIE global enable
- mret_commit  in  1  one-cycle pulse when mret retires
- irq_req  out  1  interrupt request to the trap unit
- irq_cause  out  `XLEN  mcause value: bit `XLEN-1 = 1, low bits = code
- irq_ack  in  1  trap unit has accepted the request this cycle
- csr_mip  out  `XLEN  bit 3 = sw_irq, bit 7 = tmr_irq, bit 11 = ext_irq (after sync if enabled); all other bits 0; combinational from the levels
- irq_busy  out  1  high while in the REQ or HANDLER state

Behaviour:
- Enabled pending vector:
  - pend_e = ext & mie[11] & mstatus_mie
  - pend_s = sw & mie[3] & mstatus_mie
  - pend_t = tmr & mie[7] & mstatus_mie
- Priority: MEI > MSI > MTI.
- FSM states: IDLE, REQ, HANDLER. The state is the only control register, plus a cause register.
- IDLE:
  - If any pend bit is set in cycle N, latch the highest-priority code into the cause register and enter REQ.
  - irq_req = 1 from cycle N+1. Latency is 1 cycle, input to request.
- REQ:
  - irq_req = 1; irq_cause is held stable.
  - Inputs are ignored: source withdrawal, a mie/mstatus change, or a higher-priority arrival do not alter or cancel the request.
  - irq_ack = 1 -> HANDLER; irq_req = 0 the next cycle.
  - mret_commit in REQ is ignored.
- HANDLER:
  - irq_req = 0; no new request is issued, even if sources and enables are high.
  - mret_commit = 1 -> IDLE.
  - A source still pending and enabled in the IDLE cycle re-requests one cycle later, so the earliest re-request is 2 cycles after mret_commit.
- irq_ack while in IDLE or HANDLER: ignored.
- Reset (any state, including mid-handshake), outputs take these values on the next edge:
  - state = IDLE
  - irq_req = 0
  - irq_cause = 0
  - irq_busy = 0
  - csr_mip follows the inputs (its synchronizer stages are cleared to 0 if IRQ_SYNC_EN)
- irq_cause: `XLEN-wide. Bit `XLEN-1 = 1 and bits [3:0] = code while REQ is valid; all other bits 0. Outside REQ it holds its last value (0 after reset).
- Simultaneous events:
  - Ack and a new pending source in REQ: go to HANDLER; the new source waits.
  - mret_commit and irq_ack in the same cycle in HANDLER: handled as mret only.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- When defined: ext_irq and sw_irq pass through a 2-flop synchronizer, reset to 0, before pend and csr_mip. Input-to-irq_req latency for those two sources becomes 3 cycles.
- When undefined: both are used directly and latency is 1 cycle.
- tmr_irq is never resynchronized; excp_tmr_irq delivers it in the clk domain.

Decomposition:
- Shared mcu_defines.v holds:
  - `XLEN
  - cause codes (`MEI_CODE / `MSI_CODE / `MTI_CODE) as defines, so the trap unit and mcause CSR logic agree
  - mip/mie bit positions
  - FSM state encodings
- One sub-module, excp_irq_sync (a 2-flop synchronizer with reset), instantiated only under IRQ_SYNC_EN.

Test Plan:
- Reset with all sources high, mie = 0x888, mstatus_mie = 1 -> irq_req = 0 during reset. First cycle after rst falls, IDLE latches; irq_req = 1 the cycle after, irq_cause = {1, ..., 0xB}.
- tmr_irq = 1, mie[7] = 1, mstatus_mie = 1 at cycle N -> irq_req = 1 at N+1, cause low bits = 7. Hold irq_ack = 0 for 5 cycles with tmr_irq dropped -> irq_req stays 1, cause unchanged.
- sw_irq and tmr_irq rise together, both enabled -> cause = 3. Ack -> irq_req = 0, irq_busy = 1. mret_commit pulse while tmr still high -> irq_req = 1 exactly 2 cycles after mret, cause = 7.
- ext_irq = 1 but mie[11] = 0 -> no request, csr_mip[11] = 1. Set mie[11] = 1 -> request next cycle, cause = 11.
- In HANDLER, toggle all sources and pulse irq_ack -> no irq_req. Assert rst mid-REQ -> irq_req = 0, irq_cause = 0, state IDLE next cycle.
- With IRQ_SYNC_EN: ext_irq rises at cycle N -> csr_mip[11] = 1 at N+2, irq_req = 1 at N+3.
